// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage: state encoding and occupancy width.
// The state encoding is the occupancy value, so the state register drives the occupancy port directly.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    function automatic logic [OCC_W-1:0] occ_of(input state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the stage: load enable plus synchronous clear to the bubble value.
// Clear (or reset) beats load, so a flushed slot can never capture a beat in the same cycle.
module pipe_slot #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            data_q <= FLUSH_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with flush; define PIPE_STAGE_SKID_EN for a registered in_ready plus skid slot.
// Payload is opaque, so legacy per-stage control registers map onto it as concatenated fields.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    state_e           state_q, state_d;
    logic             accept, retire;
    logic             main_load, main_clr;
    logic [WIDTH-1:0] main_d, main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load, skid_clr;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;

    // Registered ready: downstream backpressure never reaches upstream combinationally.
    assign in_ready = in_ready_q;
`else
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = in_data;
`ifdef PIPE_STAGE_SKID_EN
        skid_load = 1'b0;
        skid_clr  = 1'b0;
`endif
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && retire) begin
                        main_load = 1'b1;
                    end else if (retire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (accept) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    // Older beat leaves; the skid beat moves up, keeping order.
                    if (retire) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= (state_d != ST_SKID);
`endif
        end
    end

    pipe_slot #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main_slot (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (main_clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_skid_slot (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (skid_clr),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );
`endif

endmodule
